// File: rtl/btb_assoc_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types : shared types for the set-associative branch target buffer.
//
// Contents
//   BTB_TAG_MAX / BTB_CTR_MAX : widest tag / counter the way struct can hold.
//   btb_way_t                 : one BTB way (valid, tag, target, ctr).
//   btb_flush_state_t         : flush FSM states (IDLE, CLEAR).
//   btb_ctr_step()            : saturating up/down step of a way counter.
//
// A package cannot take parameters. btb_way_t is therefore sized for the
// largest legal configuration (TAG_BITS+IDX_BITS <= 30, CTR_BITS <= 8).
// The instantiating module passes its real widths in: it zero-extends narrower
// tags and counters into the struct, so the unused upper bits are always 0.
// -----------------------------------------------------------------------------
package rv32i_types;

   localparam int BTB_TAG_MAX = 30;
   localparam int BTB_CTR_MAX = 8;

   typedef struct packed {
      logic                   valid;
      logic [BTB_TAG_MAX-1:0] tag;
      logic [31:0]            target;
      logic [BTB_CTR_MAX-1:0] ctr;
   } btb_way_t;

   typedef enum logic [0:0] {
      FLUSH_IDLE  = 1'b0,
      FLUSH_CLEAR = 1'b1
   } btb_flush_state_t;

   // Move one step toward ctr_max (up=1) or toward 0 (up=0).
   // The counter stays put when it is already at that end.
   function automatic logic [BTB_CTR_MAX-1:0] btb_ctr_step(
      input logic [BTB_CTR_MAX-1:0] ctr,
      input logic [BTB_CTR_MAX-1:0] ctr_max,
      input logic                   up
   );
      logic [BTB_CTR_MAX-1:0] res;
      res = ctr;
      if (up && (ctr != ctr_max)) res = ctr + 1'b1;
      if (!up && (ctr != '0))     res = ctr - 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/btb_assoc_victim_sel.sv
// -----------------------------------------------------------------------------
// btb_victim_sel : picks the way to overwrite when a set allocates.
// The module is purely combinational.
//
// Ports
//   i_valid   [WAYS-1:0]  valid bits of the indexed set
//   i_rr_ptr  [PTR_W-1:0] round-robin pointer of the indexed set
//   o_victim  [PTR_W-1:0] way to overwrite
//   o_rr_next [PTR_W-1:0] pointer value to store back after the allocation
//
// The lowest-index invalid way wins. If every way is valid, the pointer picks
// the victim and then advances modulo WAYS. Filling an invalid way leaves the
// pointer unchanged.
// -----------------------------------------------------------------------------
module btb_victim_sel #(
   parameter int WAYS  = 2,
   parameter int PTR_W = 1
) (
   input  logic [WAYS-1:0]  i_valid,
   input  logic [PTR_W-1:0] i_rr_ptr,
   output logic [PTR_W-1:0] o_victim,
   output logic [PTR_W-1:0] o_rr_next
);

   always_comb begin
      o_victim  = i_rr_ptr;
      o_rr_next = PTR_W'((int'(i_rr_ptr) + 1) % WAYS);
      // Scan from the top down so that the lowest invalid way is the last
      // assignment and therefore wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!i_valid[w]) begin
            o_victim  = PTR_W'(w);
            o_rr_next = i_rr_ptr;
         end
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// -----------------------------------------------------------------------------
// btb_assoc : set-associative branch target buffer for the fetch stage.
//
// Prediction side: a combinational lookup of fetch_pc. Training side: commit
// updates from resolved branches and JALs. Allocation happens only when the
// instruction is taken. Each set has its own round-robin replacement pointer.
// A multi-cycle flush clears one set per cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fetch_pc / fetch_npc     lookup PC / predicted next PC
//   fetch_taken              hit whose counter MSB is set
//   upd_valid, upd_pc, upd_target, upd_is_jal, upd_is_br, upd_taken
//                            commit-time training port
//   flush_req / flush_busy   start a flush / flush in progress
//   stat_upd_cnt, stat_hit_cnt
//                            saturating counts of accepted updates and of
//                            accepted updates that hit
//                            (present only when BTB_STATS_EN is defined)
//
// Limits: CTR_BITS <= 8 and TAG_BITS+IDX_BITS <= 30. Both come from the
// width of btb_way_t.
// -----------------------------------------------------------------------------
module btb_assoc
   import rv32i_types::*;
#(
   parameter int SETS     = 16,
   parameter int WAYS     = 2,
   parameter int TAG_BITS = 10,
   parameter int CTR_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic [31:0] fetch_npc,
   output logic        fetch_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_is_jal,
   input  logic        upd_is_br,
   input  logic        upd_taken,
   input  logic        flush_req,
   output logic        flush_busy
`ifdef BTB_STATS_EN
   ,
   output logic [31:0] stat_upd_cnt,
   output logic [31:0] stat_hit_cnt
`endif
);

   localparam int IDX_BITS = $clog2(SETS);
   localparam int PTR_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [BTB_CTR_MAX-1:0] CTR_ONES = BTB_CTR_MAX'((1 << CTR_BITS) - 1);
   localparam logic [BTB_CTR_MAX-1:0] CTR_WEAK = BTB_CTR_MAX'(1 << (CTR_BITS - 1));

   btb_way_t            r_ways [SETS][WAYS];
   logic [PTR_W-1:0]    r_rr   [SETS];
   btb_flush_state_t    r_state;
   logic [IDX_BITS-1:0] r_fset;

   logic [IDX_BITS-1:0]    w_f_idx, w_u_idx;
   logic [BTB_TAG_MAX-1:0] w_f_tag, w_u_tag;
   logic                   w_f_hit, w_f_pt;
   logic [31:0]            w_f_tgt;
   logic                   w_u_hit, w_u_tk, w_accept;
   logic [PTR_W-1:0]       w_u_way, w_victim, w_rr_next;
   logic [BTB_CTR_MAX-1:0] w_u_ctr;
   logic [WAYS-1:0]        w_u_valid;
   logic                   w_unused_pc;

   assign w_f_idx = fetch_pc[IDX_BITS+1:2];
   assign w_f_tag = BTB_TAG_MAX'(fetch_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2]);
   assign w_u_idx = upd_pc[IDX_BITS+1:2];
   assign w_u_tag = BTB_TAG_MAX'(upd_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2]);
   // The offset bits and the bits above the tag of upd_pc take no part.
   assign w_unused_pc = ^upd_pc;

   assign flush_busy = (r_state == FLUSH_CLEAR);
   // JAL is always taken, whatever upd_taken says.
   assign w_u_tk     = upd_is_jal || upd_taken;
   // A flush request claims the cycle, so a coincident update is dropped.
   assign w_accept   = upd_valid && (upd_is_jal || upd_is_br) && !flush_busy && !flush_req;

   // Fetch lookup. Allocation only happens on a miss, so at most one way can
   // match and the order of the loop does not matter.
   always_comb begin
      w_f_hit = 1'b0;
      w_f_pt  = 1'b0;
      w_f_tgt = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_ways[w_f_idx][w].valid && (r_ways[w_f_idx][w].tag == w_f_tag)) begin
            w_f_hit = 1'b1;
            w_f_pt  = r_ways[w_f_idx][w].ctr[CTR_BITS-1];
            w_f_tgt = r_ways[w_f_idx][w].target;
         end
      end
   end

   assign fetch_taken = w_f_hit && w_f_pt && !flush_busy;
   assign fetch_npc   = fetch_taken ? w_f_tgt : (fetch_pc + 32'd4);

   // Update-side lookup in the set selected by upd_pc.
   always_comb begin
      w_u_hit   = 1'b0;
      w_u_way   = '0;
      w_u_ctr   = '0;
      w_u_valid = '0;
      for (int w = 0; w < WAYS; w++) begin
         w_u_valid[w] = r_ways[w_u_idx][w].valid;
         if (r_ways[w_u_idx][w].valid && (r_ways[w_u_idx][w].tag == w_u_tag)) begin
            w_u_hit = 1'b1;
            w_u_way = PTR_W'(w);
            w_u_ctr = r_ways[w_u_idx][w].ctr;
         end
      end
   end

   btb_victim_sel #(
      .WAYS  (WAYS),
      .PTR_W (PTR_W)
   ) u_victim_sel (
      .i_valid   (w_u_valid),
      .i_rr_ptr  (r_rr[w_u_idx]),
      .o_victim  (w_victim),
      .o_rr_next (w_rr_next)
   );

   // Targets and counters are not reset. A way is only read after its valid
   // bit has been set, and a fill writes every field of the way.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FLUSH_IDLE;
         r_fset  <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_rr[s] <= '0;
            for (int w = 0; w < WAYS; w++) r_ways[s][w].valid <= 1'b0;
         end
      end else begin
         case (r_state)
            FLUSH_IDLE: begin
               if (flush_req) begin
                  r_state <= FLUSH_CLEAR;
                  r_fset  <= '0;
               end else if (w_accept) begin
                  if (w_u_hit) begin
                     r_ways[w_u_idx][w_u_way].ctr <= btb_ctr_step(w_u_ctr, CTR_ONES, w_u_tk);
                     if (w_u_tk) r_ways[w_u_idx][w_u_way].target <= upd_target;
                  end else if (w_u_tk) begin
                     r_ways[w_u_idx][w_victim] <= '{valid:  1'b1,
                                                    tag:    w_u_tag,
                                                    target: upd_target,
                                                    ctr:    (upd_is_jal ? CTR_ONES : CTR_WEAK)};
                     r_rr[w_u_idx] <= w_rr_next;
                  end
               end
            end
            FLUSH_CLEAR: begin
               // One set per cycle. A flush_req seen here is ignored.
               for (int w = 0; w < WAYS; w++) r_ways[r_fset][w].valid <= 1'b0;
               r_rr[r_fset] <= '0;
               if (r_fset == IDX_BITS'(SETS - 1)) r_state <= FLUSH_IDLE;
               else                               r_fset  <= r_fset + 1'b1;
            end
            default: r_state <= FLUSH_IDLE;
         endcase
      end
   end

`ifdef BTB_STATS_EN
   logic [31:0] r_upd_cnt, r_hit_cnt;

   always_ff @(posedge clk) begin
      if (rst || (flush_req && (r_state == FLUSH_IDLE))) begin
         r_upd_cnt <= '0;
         r_hit_cnt <= '0;
      end else if (w_accept) begin
         if (r_upd_cnt != '1)             r_upd_cnt <= r_upd_cnt + 32'd1;
         if (w_u_hit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
      end
   end

   assign stat_upd_cnt = r_upd_cnt;
   assign stat_hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// -----------------------------------------------------------------------------
// tb_btb_assoc : self-checking bench for btb_assoc with its default parameters.
//
// A behavioural model holds per-set entry tables and a replacement pointer per
// set. It applies the prediction, training, allocation and flush rules with
// plain arithmetic. Every cycle the DUT outputs are compared with the model
// at the falling edge. Directed sequences walk the documented scenarios and
// add fixed expected values. A randomized phase follows.
// Define BTB_STATS_EN to compile in and check the statistics counters.
// -----------------------------------------------------------------------------
module tb_btb_assoc;

   localparam int SETS     = 16;
   localparam int WAYS     = 2;
   localparam int TAG_BITS = 10;
   localparam int CTR_BITS = 2;
   localparam int IDX_BITS = $clog2(SETS);
   localparam int CTR_MAX  = (1 << CTR_BITS) - 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_npc;
   logic        fetch_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_is_jal;
   logic        upd_is_br;
   logic        upd_taken;
   logic        flush_req;
   logic        flush_busy;
`ifdef BTB_STATS_EN
   logic [31:0] stat_upd_cnt;
   logic [31:0] stat_hit_cnt;
`endif

   btb_assoc #(
      .SETS     (SETS),
      .WAYS     (WAYS),
      .TAG_BITS (TAG_BITS),
      .CTR_BITS (CTR_BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_pc    (fetch_pc),
      .fetch_npc   (fetch_npc),
      .fetch_taken (fetch_taken),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_target  (upd_target),
      .upd_is_jal  (upd_is_jal),
      .upd_is_br   (upd_is_br),
      .upd_taken   (upd_taken),
      .flush_req   (flush_req),
      .flush_busy  (flush_busy)
`ifdef BTB_STATS_EN
      ,
      .stat_upd_cnt (stat_upd_cnt),
      .stat_hit_cnt (stat_hit_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          valid;
      int unsigned tag;
      logic [31:0] target;
      int          ctr;
   } ent_t;

   ent_t m_ent [SETS][WAYS];
   int   m_rr  [SETS];
   int   m_busy;            // flush cycles still to run
`ifdef BTB_STATS_EN
   longint m_upd, m_hit;
`endif

   function automatic int unsigned idx_of(input logic [31:0] pc);
      return (pc >> 2) % SETS;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return (pc >> (2 + IDX_BITS)) % (1 << TAG_BITS);
   endfunction

   task automatic model_clear();
      foreach (m_ent[s, w]) m_ent[s][w].valid = 0;
      foreach (m_rr[s]) m_rr[s] = 0;
`ifdef BTB_STATS_EN
      m_upd = 0;
      m_hit = 0;
`endif
   endtask

   task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] npc);
      int unsigned ix, tg;
      ix  = idx_of(pc);
      tg  = tag_of(pc);
      tk  = 1'b0;
      npc = pc + 32'd4;
      if (m_busy == 0) begin
         for (int w = 0; w < WAYS; w++) begin
            if (m_ent[ix][w].valid && m_ent[ix][w].tag == tg && m_ent[ix][w].ctr >= (1 << (CTR_BITS - 1))) begin
               tk  = 1'b1;
               npc = m_ent[ix][w].target;
            end
         end
      end
   endtask

   // Advance the model by one clock edge, using the inputs applied to the DUT.
   task automatic model_edge();
      int          ix, hw, v;
      int unsigned tg;
      bit          tk;
      if (rst) begin
         model_clear();
         m_busy = 0;
         return;
      end
      if (m_busy > 0) begin
         m_busy--;
         return;
      end
      if (flush_req) begin
         model_clear();
         m_busy = SETS;
         return;
      end
      if (!(upd_valid && (upd_is_jal || upd_is_br))) return;
      ix = int'(idx_of(upd_pc));
      tg = tag_of(upd_pc);
      tk = upd_is_jal || upd_taken;
      hw = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_ent[ix][w].valid && m_ent[ix][w].tag == tg) hw = w;
`ifdef BTB_STATS_EN
      if (m_upd < 64'hFFFF_FFFF) m_upd++;
      if (hw >= 0 && m_hit < 64'hFFFF_FFFF) m_hit++;
`endif
      if (hw >= 0) begin
         if (tk) begin
            if (m_ent[ix][hw].ctr < CTR_MAX) m_ent[ix][hw].ctr++;
            m_ent[ix][hw].target = upd_target;
         end else if (m_ent[ix][hw].ctr > 0) begin
            m_ent[ix][hw].ctr--;
         end
      end else if (tk) begin
         v = -1;
         for (int w = 0; w < WAYS; w++)
            if (!m_ent[ix][w].valid && v < 0) v = w;
         if (v < 0) begin
            v = m_rr[ix];
            m_rr[ix] = (m_rr[ix] + 1) % WAYS;
         end
         m_ent[ix][v].valid  = 1;
         m_ent[ix][v].tag    = tg;
         m_ent[ix][v].target = upd_target;
         m_ent[ix][v].ctr    = upd_is_jal ? CTR_MAX : (1 << (CTR_BITS - 1));
      end
   endtask

   // ---------------- driver tasks ----------------
   // Directed expectations for the next cycle, checked alongside the model.
   bit          d_en = 0;
   logic        d_tk;
   logic [31:0] d_npc;
   logic        d_busy;
`ifdef BTB_STATS_EN
   bit          d_stat_en = 0;
   logic [31:0] d_su, d_sh;
`endif

   task automatic cycle();
      logic        tk;
      logic [31:0] npc;
      @(negedge clk);
      model_lookup(fetch_pc, tk, npc);
      check("model_taken", 32'(fetch_taken), 32'(tk));
      check("model_npc", fetch_npc, npc);
      check("model_busy", 32'(flush_busy), 32'(m_busy > 0));
`ifdef BTB_STATS_EN
      check("model_stat_upd", stat_upd_cnt, m_upd[31:0]);
      check("model_stat_hit", stat_hit_cnt, m_hit[31:0]);
      if (d_stat_en) begin
         check("plan_stat_upd", stat_upd_cnt, d_su);
         check("plan_stat_hit", stat_hit_cnt, d_sh);
         d_stat_en = 0;
      end
`endif
      if (d_en) begin
         check("plan_taken", 32'(fetch_taken), 32'(d_tk));
         check("plan_npc", fetch_npc, d_npc);
         check("plan_busy", 32'(flush_busy), 32'(d_busy));
         d_en = 0;
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_in();
      upd_valid  = 1'b0;
      upd_is_jal = 1'b0;
      upd_is_br  = 1'b0;
      upd_taken  = 1'b0;
      flush_req  = 1'b0;
   endtask

   task automatic expect_next(input logic tk, input logic [31:0] npc, input logic busy);
      d_en   = 1;
      d_tk   = tk;
      d_npc  = npc;
      d_busy = busy;
   endtask

   // The same-cycle lookup is at the update PC, so it must see the old state.
   task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic jal, input logic br, input logic tk);
      fetch_pc   = pc;
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_is_jal = jal;
      upd_is_br  = br;
      upd_taken  = tk;
      cycle();
      idle_in();
   endtask

   task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] npc);
      fetch_pc = pc;
      expect_next(tk, npc, 1'b0);
      cycle();
   endtask

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 9) == 0) return $urandom();
      return 32'h6000_0000 | (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst        = 1'b1;
      fetch_pc   = 32'h6000_0000;
      upd_pc     = '0;
      upd_target = '0;
      m_busy     = 0;
      idle_in();
      @(posedge clk);
      model_edge();
      #1;
      // Reset values while rst is still held.
      expect_next(1'b0, 32'h6000_0004, 1'b0);
      cycle();
      rst = 1'b0;
      look(32'h6000_0000, 1'b0, 32'h6000_0004);

      // JAL allocates. The lookup in the same cycle sees the old state.
      expect_next(1'b0, 32'h6000_0014, 1'b0);
      do_upd(32'h6000_0010, 32'h6000_0100, 1'b1, 1'b0, 1'b1);
      look(32'h6000_0010, 1'b1, 32'h6000_0100);

      // Branch: a not-taken miss allocates nothing. A taken branch allocates
      // weakly taken. One not-taken then drops the counter to 01.
      do_upd(32'h6000_0020, 32'h6000_0200, 1'b0, 1'b1, 1'b0);
      look(32'h6000_0020, 1'b0, 32'h6000_0024);
      do_upd(32'h6000_0020, 32'h6000_0200, 1'b0, 1'b1, 1'b1);
      look(32'h6000_0020, 1'b1, 32'h6000_0200);
      do_upd(32'h6000_0020, 32'h6000_0200, 1'b0, 1'b1, 1'b0);
      look(32'h6000_0020, 1'b0, 32'h6000_0024);

      // Three tags in set 0: the third evicts way 0, the fourth evicts way 1.
      do_upd(32'h6000_0040, 32'h6000_1040, 1'b0, 1'b1, 1'b1);
      do_upd(32'h6000_0440, 32'h6000_1440, 1'b0, 1'b1, 1'b1);
      do_upd(32'h6000_0840, 32'h6000_1840, 1'b0, 1'b1, 1'b1);
      look(32'h6000_0040, 1'b0, 32'h6000_0044);
      look(32'h6000_0440, 1'b1, 32'h6000_1440);
      look(32'h6000_0840, 1'b1, 32'h6000_1840);
      do_upd(32'h6000_0C40, 32'h6000_1C40, 1'b0, 1'b1, 1'b1);
      look(32'h6000_0440, 1'b0, 32'h6000_0444);
      look(32'h6000_0840, 1'b1, 32'h6000_1840);
      look(32'h6000_0C40, 1'b1, 32'h6000_1C40);

      // PC+4 wraps around.
      look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

      // Flush. The update in the same cycle as flush_req is dropped.
      fetch_pc   = 32'h6000_0010;
      flush_req  = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = 32'h6000_00C0;
      upd_target = 32'h6000_0C00;
      upd_is_jal = 1'b1;
      expect_next(1'b1, 32'h6000_0100, 1'b0);
      cycle();
      idle_in();
      // flush_busy stays high for exactly SETS cycles. Lookups miss, and an
      // update issued during the flush is ignored.
      for (int i = 0; i < SETS; i++) begin
         fetch_pc = 32'h6000_0010;
         if (i == 5) begin
            upd_valid  = 1'b1;
            upd_pc     = 32'h6000_0080;
            upd_target = 32'h6000_0800;
            upd_is_jal = 1'b1;
         end
         expect_next(1'b0, 32'h6000_0014, 1'b1);
         cycle();
         idle_in();
      end
      // The first cycle after the flush accepts an update again.
      expect_next(1'b0, 32'h6000_0054, 1'b0);
      do_upd(32'h6000_0050, 32'h6000_0500, 1'b1, 1'b0, 1'b1);
      look(32'h6000_0050, 1'b1, 32'h6000_0500);
      look(32'h6000_0010, 1'b0, 32'h6000_0014);
      look(32'h6000_00C0, 1'b0, 32'h6000_00C4);
      look(32'h6000_0080, 1'b0, 32'h6000_0084);
      look(32'h6000_0840, 1'b0, 32'h6000_0844);

      // Reset in the middle of a flush returns to idle, all entries invalid.
      do_upd(32'h6000_0010, 32'h6000_0100, 1'b1, 1'b0, 1'b1);
      flush_req = 1'b1;
      cycle();
      idle_in();
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      look(32'h6000_0010, 1'b0, 32'h6000_0014);
      look(32'h6000_0050, 1'b0, 32'h6000_0054);

`ifdef BTB_STATS_EN
      // Five accepted updates, two of which hit. A flush clears both counts.
      do_upd(32'h6000_0100, 32'h6000_1000, 1'b1, 1'b0, 1'b1);
      do_upd(32'h6000_0100, 32'h6000_1000, 1'b1, 1'b0, 1'b1);
      do_upd(32'h6000_0104, 32'h6000_1004, 1'b0, 1'b1, 1'b1);
      do_upd(32'h6000_0104, 32'h6000_1004, 1'b0, 1'b1, 1'b0);
      do_upd(32'h6000_0108, 32'h6000_1008, 1'b0, 1'b1, 1'b0);
      d_stat_en = 1;
      d_su      = 32'd5;
      d_sh      = 32'd2;
      flush_req = 1'b1;
      cycle();
      idle_in();
      d_stat_en = 1;
      d_su      = 32'd0;
      d_sh      = 32'd0;
      for (int i = 0; i < SETS; i++) cycle();
`endif

      // Randomized traffic, checked against the model every cycle.
      for (int i = 0; i < 800; i++) begin
         idle_in();
         fetch_pc = rand_pc();
         if ($urandom_range(0, 99) < 60) begin
            int kind;
            kind       = $urandom_range(0, 4);
            upd_valid  = 1'b1;
            upd_pc     = ($urandom_range(0, 1) == 0) ? fetch_pc : rand_pc();
            upd_target = $urandom();
            upd_is_jal = (kind == 0) || (kind == 4);
            upd_is_br  = (kind == 1) || (kind == 2) || (kind == 4);
            upd_taken  = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 99) < 2) flush_req = 1'b1;
         rst = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0;
      idle_in();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Set-associative, parametrised branch target buffer for the fetch stage of the out-of-order core. It provides a combinational next-PC prediction for the fetch PC and is trained at commit by resolved branches and JALs. It generalises the direct-mapped BTB with:
- configurable sets, ways, tag width and counter width;
- per-set round-robin replacement;
- allocate-on-taken policy;
- a multi-cycle flush state machine.

## Interface
Parameters:
- SETS, 16, number of sets; power of 2, ≥2; IDX_BITS = $clog2(SETS)
- WAYS, 2, ways per set; power of 2, ≥1
- TAG_BITS, 10, stored partial tag width; TAG_BITS+IDX_BITS ≤ 30
- CTR_BITS, 2, saturating counter width, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_pc  in  32  PC being fetched
- fetch_npc  out  32  predicted next PC
- fetch_taken  out  1  prediction is taken; fetch_npc is the stored target
- upd_valid  in  1  commit update strobe
- upd_pc  in  32  PC of committing control-flow instruction
- upd_target  in  32  resolved target address
- upd_is_jal  in  1  instruction is JAL
- upd_is_br  in  1  instruction is conditional branch
- upd_taken  in  1  branch resolved taken; ignored for JAL, which is always taken
- flush_req  in  1  single-cycle pulse; invalidate all entries
- flush_busy  out  1  flush in progress
- stat_upd_cnt  out  32  only with BTB_STATS_EN; accepted updates
- stat_hit_cnt  out  32  only with BTB_STATS_EN; accepted updates that hit

## Operation
Address fields:
- index = pc[IDX_BITS+1:2]
- tag = pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2]

Each way holds: valid, tag, 32-bit target, CTR_BITS counter. An entry predicts taken when its counter MSB = 1.

Lookup (combinational):
- Hit = valid && tag match in the indexed set.
- Hit and predicts taken: fetch_npc = target, fetch_taken = 1.
- Otherwise: fetch_npc = fetch_pc+4, fetch_taken = 0.
- While flush_busy = 1, lookups always miss.

Update, accepted when upd_valid && (upd_is_jal || upd_is_br) && !flush_busy && !flush_req:
- Hit, taken (or JAL): counter saturating +1; target ← upd_target.
- Hit, not-taken: counter saturating −1; target unchanged.
- Miss, taken (or JAL): allocate. Victim is the lowest-index invalid way; if the set is full, the set's round-robin pointer selects the victim and then advances modulo WAYS.
  - Fill: valid = 1, tag, target.
  - Counter = all-ones for JAL; 2^(CTR_BITS−1) (weakly taken) for a branch.
- Miss, not-taken: no allocation, no state change.
- At most one way matches; this is guaranteed because allocation only happens on a miss.

Flush FSM:
- States IDLE and CLEAR.
- IDLE → CLEAR on flush_req; the set counter starts at 0.
- CLEAR: clears valid bits and the RR pointer of one set per cycle; returns to IDLE after set SETS−1.
- flush_req while in CLEAR is ignored.

## Timing
- Reset: all valid bits = 0, RR pointers = 0, FSM = IDLE, flush_busy = 0, stat counters = 0.
- Reset outputs: fetch_npc = fetch_pc+4, fetch_taken = 0.
- rst asserted during CLEAR returns the FSM to IDLE with every entry invalid.
- An update is written at the clock edge. A lookup in the same cycle sees pre-update state; a lookup in the next cycle sees the new entry.
- flush_req at edge N: flush_busy = 1 for cycles N+1 … N+SETS; the first update accepted again is in cycle N+SETS+1.
- An update coincident with flush_req is dropped.
- PC+4 wraps modulo 2^32.

## Configuration
- BTB_STATS_EN defined: stat_upd_cnt and stat_hit_cnt ports exist. Both are 32-bit counters that saturate at 2^32−1, increment on accepted updates, and clear on rst and on flush_req acceptance.
- BTB_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- rv32i_types holds:
  - the btb_way_t struct (valid, tag, target, ctr), with parametric widths passed via the module;
  - the btb_flush_state_t enum (IDLE, CLEAR).
- One sub-module: btb_victim_sel. Inputs are the set's valid vector and RR pointer; outputs are the victim way and the next pointer. Combinational.

## Test plan
- Reset, then fetch_pc=0x6000_0000 → fetch_taken=0, fetch_npc=0x6000_0004.
- JAL update pc=0x6000_0010, target=0x6000_0100 → next cycle, fetch_pc=0x6000_0010 gives fetch_taken=1, fetch_npc=0x6000_0100.
- Branch at 0x6000_0020 resolved not-taken on a miss → no allocation. Then taken → allocates weakly taken (fetch_taken=1). Then not-taken once → counter 01, fetch_taken=0.
- WAYS=2: taken branches at three PCs with the same index and different tags (0x6000_0040, 0x6000_0440, 0x6000_0840) → the third evicts way 0 (the 0x…040 entry now misses); a fourth evicts way 1.
- flush_req pulse → flush_busy high for exactly SETS cycles, lookups miss, and an update issued during the flush has no effect. All entries miss afterwards.
- BTB_STATS_EN: 5 updates, 2 of them hits → stat_upd_cnt=5, stat_hit_cnt=2; flush_req → both read 0.
